dma_priority_arbiter: RTL and testbench
=======================================

// Module: dma_priority_arbiter
// PURPOSE
//  Channel request/priority stage directly upstream of DMA timing and control.
//  Qualifies DREQ[3:0] and software requests against the mask register, then picks one channel
//  (fixed or rotating priority) and raises validRequest toward timing/control.
//  Locks the winner and drives one-hot DACK while timing/control asserts assertDACK.
// PARAMETERS
//  NUM_CH          4    channel count; only 4 is supported and the package constant must equal it
//  RESET_LOWEST    3    channel index holding lowest priority after reset
// PORTS
//  CLK               in   1       system clock
//  RESET             in   1       synchronous, active-high reset
//  DREQ              in   4       raw channel requests
//  dreqSenseLow      in   1       command reg bit: 1 = DREQ active-low
//  maskReg           in   4       1 = channel hardware request masked
//  requestReg        in   4       software requests; mask does not apply
//  rotatingPriority  in   1       command reg bit: 0 = fixed, 1 = rotating
//  assertDACK        in   1       from timing/control: grant bus cycle active
//  intEOP            in   1       from timing/control: terminal count / end of process
//  validRequest      out  1       registered; a qualified winner is pending or in service
//  activeChannel     out  2       registered index of the locked winner
//  DACK              out  4       one-hot, active-high acknowledge
//  clearSwRequest    out  4       1-cycle pulse clearing requestReg bit on EOP
// BEHAVIOUR
//  Reset values: state=IDLE, validRequest=0, activeChannel=0, DACK=0, clearSwRequest=0, lowestPri=RESET_LOWEST.
//  Request qualification: reqEff[i] = ((DREQ[i]^dreqSenseLow) & ~maskReg[i]) | requestReg[i].
//  Priority:
//   - fixed: ch0 highest, ch3 lowest.
//   - rotating: search starts at lowestPri+1 mod 4, wrapping.
//  FSM states: IDLE, PEND, SERVICE.
//   IDLE:    if |reqEff -> latch winner into activeChannel, validRequest<=1, go to PEND; else stay.
//   PEND:    if reqEff[activeChannel]==0 (dropped or masked) -> validRequest<=0, go to IDLE.
//            Else if assertDACK -> DACK<=onehot(activeChannel), go to SERVICE.
//            A higher-priority request arriving in PEND does NOT preempt.
//   SERVICE: winner held; DACK held while assertDACK==1.
//            On assertDACK==0 or intEOP==1 -> DACK<=0, validRequest<=0, go to IDLE.
//            In rotating mode, lowestPri<=activeChannel on the same edge.
//            On intEOP only, clearSwRequest[activeChannel] pulses for one cycle.
//  Latency: reqEff to validRequest = 1 clk; assertDACK to DACK = 1 clk.
//  At least one IDLE cycle between services; rearbitration happens in that cycle.
//  Requests active on the release edge compete in the following IDLE cycle.
//  Simultaneous intEOP and assertDACK fall: treated as a single EOP release.
//  intEOP outside SERVICE: ignored.
//  RESET mid-service: all outputs return to reset values at the next edge; no clearSwRequest pulse.
//  Mode switch (rotatingPriority) is sampled at every arbitration; lowestPri is retained across switches.
// CONFIGURATION
//  DMA_DREQ_SYNC_EN defined:
//   - DREQ passes a 2-flop synchronizer before qualification.
//   - reqEff to validRequest latency becomes 3 clk.
//   - Synchronizer flops reset to inactive level 0 (pre-polarity).
//   - requestReg path is not synchronized.
//  Undefined: DREQ is used directly; latency 1 clk.
// STRUCTURE
//  dmaPkg: NUM_CH constant; arbState_t enum {IDLE,PEND,SERVICE} (one-hot encoded); chIdx_t logic[1:0].
//  Sub-module dma_priority_encoder: combinational (reqEff, lowestPri, rotating) -> winner, anyReq.
//  This module owns the FSM, latches, synchronizer and output registers.
// TESTING
//  1 Fixed, DREQ=4'b1010, mask=0 -> next clk validRequest=1, activeChannel=1;
//    assertDACK=1 -> next clk DACK=4'b0010.
//  2 Rotating: service ch1 (assertDACK falls) -> DREQ=4'b1111 -> activeChannel=2; after it, ch3 wins, then ch0.
//  3 maskReg=4'b0001, DREQ=4'b0001 -> validRequest stays 0;
//    requestReg=4'b0001 -> validRequest=1, activeChannel=0.
//  4 Grant ch2 in PEND, drop DREQ[2] before assertDACK -> validRequest=0, DACK=0, back to IDLE in 1 clk.
//  5 Software request ch3 in SERVICE, intEOP=1 -> clearSwRequest=4'b1000 for exactly 1 clk, DACK=0.
//    Also: RESET mid-SERVICE -> all outputs reset next edge.
//  6 With DMA_DREQ_SYNC_EN: DREQ[0] rise -> validRequest after 3 clk; dreqSenseLow=1 with DREQ=4'b1110 -> ch0 wins.

Source files
------------

// File: rtl/dma_priority_arbiter_pkg.sv
// dma_priority_arbiter_pkg: shared channel count, index type and one-hot FSM state encodings.
package dma_priority_arbiter_pkg;
    localparam int NUM_CH = 4;
    typedef logic [1:0] ch_idx_t;
    typedef logic [2:0] arb_state_t;
    localparam arb_state_t IDLE    = 3'b001;
    localparam arb_state_t PEND    = 3'b010;
    localparam arb_state_t SERVICE = 3'b100;
    function automatic logic [NUM_CH-1:0] onehot(input ch_idx_t c);
        return NUM_CH'(1) << c;
    endfunction
endpackage

// File: rtl/dma_priority_arbiter_if.sv
// dma_priority_arbiter_if: request/grant bundle between the register file, timing/control and the arbiter.
interface dma_priority_arbiter_if;
    logic [3:0] DREQ;
    logic       dreqSenseLow;
    logic [3:0] maskReg;
    logic [3:0] requestReg;
    logic       rotatingPriority;
    logic       assertDACK;
    logic       intEOP;
    logic       validRequest;
    logic [1:0] activeChannel;
    logic [3:0] DACK;
    logic [3:0] clearSwRequest;
    modport master (
        output DREQ, dreqSenseLow, maskReg, requestReg, rotatingPriority, assertDACK, intEOP,
        input  validRequest, activeChannel, DACK, clearSwRequest
    );
    modport slave (
        input  DREQ, dreqSenseLow, maskReg, requestReg, rotatingPriority, assertDACK, intEOP,
        output validRequest, activeChannel, DACK, clearSwRequest
    );
endinterface

// File: rtl/dma_priority_arbiter_encoder.sv
// dma_priority_encoder: picks the winning channel, fixed (ch0 first) or rotating (after lowest_i).
module dma_priority_encoder
    import dma_priority_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  ch_idx_t           lowest_i,
    input  logic              rotating_i,
    output ch_idx_t           winner_o,
    output logic              any_o
);
    ch_idx_t idx;
    always_comb begin
        winner_o = '0;
        idx      = '0;
        // scan from lowest to highest priority so the last hit is the winner
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = rotating_i ? lowest_i + ch_idx_t'(k + 1) : ch_idx_t'(k);
            if (req_i[idx]) winner_o = idx;
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: qualifies DMA requests, arbitrates, locks the winner and drives DACK.
// Define DMA_DREQ_SYNC_EN to pass DREQ through a 2-flop synchronizer before qualification.
module dma_priority_arbiter
    import dma_priority_arbiter_pkg::*;
#(
    parameter ch_idx_t RESET_LOWEST = 2'd3
) (
    input logic                    CLK,
    input logic                    RESET,
    dma_priority_arbiter_if.slave  bus
);
    logic [NUM_CH-1:0] dreq_s, req_eff, dack_q, dack_d, clr_q, clr_d;
    arb_state_t        state_q, state_d;
    ch_idx_t           act_q, act_d, low_q, low_d, winner;
    logic              valid_q, valid_d, any_req;
`ifdef DMA_DREQ_SYNC_EN
    logic [NUM_CH-1:0] sync1_q, sync2_q;
    always_ff @(posedge CLK) begin
        if (RESET) {sync2_q, sync1_q} <= '0;
        else       {sync2_q, sync1_q} <= {sync1_q, bus.DREQ};
    end
    assign dreq_s = sync2_q;
`else
    assign dreq_s = bus.DREQ;
`endif
    assign req_eff = ((dreq_s ^ {NUM_CH{bus.dreqSenseLow}}) & ~bus.maskReg) | bus.requestReg;

    dma_priority_encoder u_enc (
        .req_i      (req_eff),
        .lowest_i   (low_q),
        .rotating_i (bus.rotatingPriority),
        .winner_o   (winner),
        .any_o      (any_req)
    );

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        valid_d = valid_q;
        dack_d  = dack_q;
        low_d   = low_q;
        clr_d   = '0;
        case (state_q)
            IDLE: if (any_req) begin
                act_d   = winner;
                valid_d = 1'b1;
                state_d = PEND;
            end
            PEND: if (!req_eff[act_q]) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end else if (bus.assertDACK) begin
                dack_d  = onehot(act_q);
                state_d = SERVICE;
            end
            SERVICE: if (!bus.assertDACK || bus.intEOP) begin
                dack_d  = '0;
                valid_d = 1'b0;
                state_d = IDLE;
                low_d   = bus.rotatingPriority ? act_q : low_q;
                clr_d   = bus.intEOP ? onehot(act_q) : '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            act_q   <= '0;
            valid_q <= 1'b0;
            dack_q  <= '0;
            clr_q   <= '0;
            low_q   <= RESET_LOWEST;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            valid_q <= valid_d;
            dack_q  <= dack_d;
            clr_q   <= clr_d;
            low_q   <= low_d;
        end
    end

    assign bus.validRequest   = valid_q;
    assign bus.activeChannel  = act_q;
    assign bus.DACK           = dack_q;
    assign bus.clearSwRequest = clr_q;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb_dma_priority_arbiter: directed and randomized checks against a behavioural arbiter model.
module tb_dma_priority_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dma_priority_arbiter_if bus();
    dma_priority_arbiter dut (.CLK(clk), .RESET(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    int         m_phase;
    logic [1:0] m_act, m_low;
    logic       m_valid;
    logic [3:0] m_dack, m_clr, m_hist1, m_hist2;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] pick(input logic [3:0] r, input logic rot, input logic [1:0] low);
        int best = 0;
        int best_rank = 99;
        for (int i = 0; i < 4; i++) begin
            int rank = rot ? (i - int'(low) - 1 + 8) % 4 : i;
            if (r[i] && rank < best_rank) begin
                best = i;
                best_rank = rank;
            end
        end
        return 2'(best);
    endfunction

    task automatic model_step();
        logic [3:0] src, eff;
`ifdef DMA_DREQ_SYNC_EN
        src = m_hist2;
`else
        src = bus.DREQ;
`endif
        eff = ((src ^ {4{bus.dreqSenseLow}}) & ~bus.maskReg) | bus.requestReg;
        m_clr = '0;
        if (rst) begin
            m_phase = 0; m_act = 0; m_low = 2'd3; m_valid = 0; m_dack = 0;
            m_hist1 = 0; m_hist2 = 0;
            return;
        end
        m_hist2 = m_hist1;
        m_hist1 = bus.DREQ;
        if (m_phase == 0) begin
            if (eff != 0) begin
                m_act = pick(eff, bus.rotatingPriority, m_low);
                m_valid = 1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!eff[m_act]) begin
                m_valid = 0;
                m_phase = 0;
            end else if (bus.assertDACK) begin
                m_dack = 4'b0001 << m_act;
                m_phase = 2;
            end
        end else if (!bus.assertDACK || bus.intEOP) begin
            m_dack = 0;
            m_valid = 0;
            m_phase = 0;
            if (bus.rotatingPriority) m_low = m_act;
            if (bus.intEOP) m_clr = 4'b0001 << m_act;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("validRequest", 8'(bus.validRequest), 8'(m_valid));
        check("activeChannel", 8'(bus.activeChannel), 8'(m_act));
        check("DACK", 8'(bus.DACK), 8'(m_dack));
        check("clearSwRequest", 8'(bus.clearSwRequest), 8'(m_clr));
    endtask

    task automatic reset_dut();
        rst = 1;
        bus.DREQ = 0; bus.dreqSenseLow = 0; bus.maskReg = 0; bus.requestReg = 0;
        bus.rotatingPriority = 0; bus.assertDACK = 0; bus.intEOP = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic serve_next(input string tag, input logic [1:0] exp_ch);
        bus.assertDACK = 0;
        tick();
        tick();
        check(tag, 8'(bus.activeChannel), 8'(exp_ch));
        bus.assertDACK = 1;
        tick();
    endtask

    initial begin
        reset_dut();
        check("reset_valid", 8'(bus.validRequest), 8'd0);
        check("reset_act", 8'(bus.activeChannel), 8'd0);
        check("reset_dack", 8'(bus.DACK), 8'd0);

        bus.DREQ = 4'b1010;
        repeat (3) tick();
        check("t1_valid", 8'(bus.validRequest), 8'd1);
        check("t1_act", 8'(bus.activeChannel), 8'd1);
        bus.assertDACK = 1;
        tick();
        check("t1_dack", 8'(bus.DACK), 8'b0010);

        reset_dut();
        bus.rotatingPriority = 1;
        bus.DREQ = 4'b0010;
        repeat (3) tick();
        check("t2_first", 8'(bus.activeChannel), 8'd1);
        bus.assertDACK = 1;
        bus.DREQ = 4'b1111;
        repeat (3) tick();
        serve_next("t2_rot_ch2", 2'd2);
        serve_next("t2_rot_ch3", 2'd3);
        serve_next("t2_rot_ch0", 2'd0);

        reset_dut();
        bus.maskReg = 4'b0001;
        bus.DREQ = 4'b0001;
        repeat (3) tick();
        check("t3_masked", 8'(bus.validRequest), 8'd0);
        bus.requestReg = 4'b0001;
        tick();
        check("t3_sw_valid", 8'(bus.validRequest), 8'd1);
        check("t3_sw_act", 8'(bus.activeChannel), 8'd0);

        reset_dut();
        bus.DREQ = 4'b0100;
        repeat (3) tick();
        check("t4_pend_act", 8'(bus.activeChannel), 8'd2);
        bus.DREQ = 4'b0000;
        repeat (3) tick();
        check("t4_drop_valid", 8'(bus.validRequest), 8'd0);
        check("t4_drop_dack", 8'(bus.DACK), 8'd0);

        reset_dut();
        bus.requestReg = 4'b1000;
        tick();
        bus.assertDACK = 1;
        tick();
        check("t5_dack", 8'(bus.DACK), 8'b1000);
        bus.intEOP = 1;
        tick();
        check("t5_clr", 8'(bus.clearSwRequest), 8'b1000);
        check("t5_eop_dack", 8'(bus.DACK), 8'd0);
        bus.intEOP = 0; bus.requestReg = 0; bus.assertDACK = 0;
        tick();
        check("t5_clr_pulse", 8'(bus.clearSwRequest), 8'd0);
        bus.requestReg = 4'b1000;
        tick();
        bus.assertDACK = 1;
        tick();
        rst = 1;
        tick();
        rst = 0;
        check("t5_rst_dack", 8'(bus.DACK), 8'd0);
        check("t5_rst_valid", 8'(bus.validRequest), 8'd0);
        check("t5_rst_clr", 8'(bus.clearSwRequest), 8'd0);

        reset_dut();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) bus.DREQ = 4'($urandom);
            if ($urandom_range(0, 15) == 0) bus.maskReg = 4'($urandom);
            if ($urandom_range(0, 15) == 0) bus.requestReg = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 63) == 0) bus.dreqSenseLow = ~bus.dreqSenseLow;
            if ($urandom_range(0, 31) == 0) bus.rotatingPriority = ~bus.rotatingPriority;
            bus.assertDACK = $urandom_range(0, 9) < 7;
            bus.intEOP = $urandom_range(0, 9) == 0;
            rst = $urandom_range(0, 199) == 0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
